// File: rtl/ingress_frame_writer.sv
// Receive-side frame writer: packs RX bytes into memory blocks, links blocks from the
// free list into a chain, then hands the head pointer to the VOQ or the drop path.
package rx_tx_pkg;
  parameter int DATA_WIDTH = 8;
endpackage

module ingress_frame_writer #(
  parameter int ADDR_W      = 6,
  parameter int BLOCK_BYTES = 64,
  parameter int DATA_WIDTH  = rx_tx_pkg::DATA_WIDTH,
  localparam int LEN_W      = $clog2(BLOCK_BYTES + 1)
) (
  input  logic                                   switch_clk,
  input  logic                                   switch_rst_n,
  input  logic [DATA_WIDTH-1:0]                  rx_data_i,
  input  logic                                   rx_valid_i,
  input  logic                                   rx_last_i,
  input  logic                                   rx_err_i,
  output logic                                   rx_ready_o,
  input  logic                                   free_valid_i,
  input  logic [ADDR_W-1:0]                      free_ptr_i,
  output logic                                   free_pop_o,
  output logic                                   mem_we_o,
  output logic [ADDR_W-1:0]                      mem_addr_o,
  output logic [BLOCK_BYTES-1:0][DATA_WIDTH-1:0] mem_data_o,
  output logic [ADDR_W-1:0]                      mem_next_ptr_o,
  output logic                                   mem_last_o,
  output logic [LEN_W-1:0]                       mem_len_o,
  output logic                                   voq_write_req_o,
  output logic [ADDR_W-1:0]                      voq_ptr_o,
  output logic                                   drop_req_o,
  output logic [ADDR_W-1:0]                      drop_ptr_o
);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_LINK, S_WLAST, S_DONE} state_e;

  state_e                                 state_q;
  logic [LEN_W-1:0]                       cnt_q;
  logic [ADDR_W-1:0]                      head_q, cur_q;
  logic                                   err_q;
  logic [BLOCK_BYTES-1:0][DATA_WIDTH-1:0] stage_q;
  logic                                   acc;

  assign acc = (state_q == S_FILL) && rx_valid_i;

  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      head_q  <= '0;
      cur_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (rx_valid_i && free_valid_i) begin
          head_q  <= free_ptr_i;
          cur_q   <= free_ptr_i;
          cnt_q   <= '0;
          err_q   <= 1'b0;
          state_q <= S_FILL;
        end
        S_FILL: if (rx_valid_i) begin
          cnt_q <= cnt_q + 1'b1;
          err_q <= err_q | rx_err_i;
          // frame end wins over block-full so a frame filling its block exactly needs no link
          if (rx_last_i)                               state_q <= S_WLAST;
          else if (cnt_q == LEN_W'(BLOCK_BYTES - 1))  state_q <= S_LINK;
        end
        S_LINK: if (free_valid_i) begin
          cur_q   <= free_ptr_i;
          cnt_q   <= '0;
          state_q <= S_FILL;
        end
        S_WLAST: state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      stage_q <= '0;
    end else begin
      for (int i = 0; i < BLOCK_BYTES; i++)
        if (acc && cnt_q == LEN_W'(i)) stage_q[i] <= rx_data_i;
    end
  end

  logic              rdy_c, pop_c, we_c, last_c, voq_c, drop_c;
  logic [ADDR_W-1:0] addr_c, next_c, vptr_c, dptr_c;
  logic [LEN_W-1:0]  len_c;

  always_comb begin
    rdy_c  = 1'b0;
    pop_c  = 1'b0;
    we_c   = 1'b0;
    last_c = 1'b0;
    voq_c  = 1'b0;
    drop_c = 1'b0;
    addr_c = '0;
    next_c = '0;
    vptr_c = '0;
    dptr_c = '0;
    len_c  = '0;
    case (state_q)
      S_IDLE: pop_c = rx_valid_i && free_valid_i;
      S_FILL: rdy_c = 1'b1;
      S_LINK: if (free_valid_i) begin
        pop_c  = 1'b1;
        we_c   = 1'b1;
        addr_c = cur_q;
        next_c = free_ptr_i;
        len_c  = LEN_W'(BLOCK_BYTES);
      end
      S_WLAST: begin
        we_c   = 1'b1;
        addr_c = cur_q;
        last_c = 1'b1;
        len_c  = cnt_q;
      end
      S_DONE: if (err_q) begin
        drop_c = 1'b1;
        dptr_c = head_q;
      end else begin
        voq_c  = 1'b1;
        vptr_c = head_q;
      end
      default: ;
    endcase
  end

  // reset forces every output low immediately, independent of the clock
  assign rx_ready_o      = switch_rst_n & rdy_c;
  assign free_pop_o      = switch_rst_n & pop_c;
  assign mem_we_o        = switch_rst_n & we_c;
  assign mem_last_o      = switch_rst_n & last_c;
  assign voq_write_req_o = switch_rst_n & voq_c;
  assign drop_req_o      = switch_rst_n & drop_c;
  assign mem_addr_o      = switch_rst_n ? addr_c : '0;
  assign mem_next_ptr_o  = switch_rst_n ? next_c : '0;
  assign mem_len_o       = switch_rst_n ? len_c  : '0;
  assign voq_ptr_o       = switch_rst_n ? vptr_c : '0;
  assign drop_ptr_o      = switch_rst_n ? dptr_c : '0;
  assign mem_data_o      = switch_rst_n ? stage_q : '0;

endmodule
